// File: rtl/elevator_call_ctrl.sv
// Call latch and SCAN step sequencer feeding the elevator floor register.
// Optional watchdog on the WAIT state is enabled by defining CALL_WATCHDOG_EN.
module elevator_call_ctrl #(
  parameter int unsigned DOOR_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] call_req,
  input  logic [1:0] floor,
  output logic       up,
  output logic       down,
  output logic       door_open,
  output logic [2:0] pending,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned CNT_MAX = (DOOR_CYCLES > TIMEOUT_CYCLES) ? DOOR_CYCLES : TIMEOUT_CYCLES;
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES);

  if (CNT_MAX >= (32'd1 << CNT_W)) begin : g_cnt_w_too_narrow
    $error("CNT_W too narrow for the door/timeout counter");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_WAIT  = 3'd2,
    S_DOOR  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       start_q, start_d;
  logic [2:0]       clr, pending_d;
  logic             up_d, down_d;

  logic [2:0] fmask, above_mask, below_mask;
  logic       own_hit, calls_above, calls_below, ahead, behind;
  logic       moved;

  // Floor-relative call masks: bit i is floor i+1.
  always_comb begin
    fmask      = 3'b000;
    above_mask = 3'b000;
    below_mask = 3'b000;
    case (floor)
      2'd1: begin fmask = 3'b001; above_mask = 3'b110; end
      2'd2: begin fmask = 3'b010; above_mask = 3'b100; below_mask = 3'b001; end
      2'd3: begin fmask = 3'b100; below_mask = 3'b011; end
      default: ;
    endcase
  end

  assign own_hit     = |(pending & fmask);
  assign calls_above = |(pending & above_mask);
  assign calls_below = |(pending & below_mask);
  assign ahead       = (dir_q == DIR_UP) ? calls_above : calls_below;
  assign behind      = (dir_q == DIR_UP) ? calls_below : calls_above;
  assign moved       = (floor != 2'd0) && (floor != start_q);

  // Next-state, counter and step-pulse decisions.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    clr     = 3'b000;
    up_d    = 1'b0;
    down_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (floor != 2'd0) begin
          if (own_hit) begin
            state_d = S_DOOR;
            clr     = fmask;
            cnt_d   = DOOR_LOAD;
          end else if (ahead) begin
            state_d = S_STEP;
          end else if (behind) begin
            dir_d   = ~dir_q;
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        up_d    = (dir_q == DIR_UP);
        down_d  = (dir_q == DIR_DN);
        start_d = floor;
        state_d = S_WAIT;
`ifdef CALL_WATCHDOG_EN
        cnt_d   = CNT_W'(TIMEOUT_CYCLES);
`endif
      end
      S_WAIT: begin
        if (moved) begin
          if (own_hit) begin
            state_d = S_DOOR;
            clr     = fmask;
            cnt_d   = DOOR_LOAD;
          end else if (ahead) begin
            state_d = S_STEP;
          end else begin
            state_d = S_IDLE;
          end
        end
`ifdef CALL_WATCHDOG_EN
        else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      S_DOOR: begin
        // A repeat call at the served floor is absorbed and holds the door.
        clr = fmask;
        if (|(call_req & fmask)) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef CALL_WATCHDOG_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign pending_d = (pending | call_req) & ~clr;

  // All state and outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      start_q   <= 2'd0;
      pending   <= 3'b000;
      up        <= 1'b0;
      down      <= 1'b0;
      door_open <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      pending   <= pending_d;
      up        <= up_d;
      down      <= down_d;
      door_open <= (state_d == S_DOOR);
      busy      <= (state_d != S_IDLE);
    end
  end

`ifdef CALL_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault <= 1'b0;
    else          fault <= (state_d == S_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_call_ctrl.sv
// Directed bench for elevator_call_ctrl with a behavioural floor register model.
module tb_elevator_call_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] call_req = 3'b000;
  logic [1:0] fl = 2'd0;
  logic       up, down, door_open, busy, fault;
  logic [2:0] pending;

  logic       load_en = 1'b1;
  logic [1:0] load_val = 2'd1;
  logic       freeze = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Floor register: follows step pulses, clamped at the end floors.
  always @(posedge clk) begin
    if (load_en) fl <= load_val;
    else if (!freeze) begin
      if (up && fl != 2'd3)        fl <= fl + 2'd1;
      else if (down && fl != 2'd1) fl <= fl - 2'd1;
    end
  end

  elevator_call_ctrl #(.DOOR_CYCLES(4), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .call_req(call_req), .floor(fl),
    .up(up), .down(down), .door_open(door_open), .pending(pending),
    .busy(busy), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("up_down_exclusive", 32'(up & down), 32'd0);
    chk("no_up_at_top", 32'(up && (fl == 2'd3)), 32'd0);
    chk("no_down_at_bottom", 32'(down && (fl == 2'd1)), 32'd0);
  endtask

  task automatic door_len(input string tag, input int start_cnt, input int exp_len);
    int c = start_cnt;
    int g = 0;
    while (door_open === 1'b1 && g < 40) begin
      c++;
      g++;
      tick();
    end
    chk(tag, 32'(c), 32'(exp_len));
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((busy !== 1'b0 || pending !== 3'b000) && g < 300) begin
      g++;
      tick();
    end
    chk(tag, 32'({pending, busy}), 32'd0);
  endtask

  task automatic set_floor(input logic [1:0] f);
    load_val = f;
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up", 32'(up), 32'd0);
    chk("rst_down", 32'(down), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    reset_n = 1'b1;
    tick();
    load_en = 1'b0;

    // A: floor 1, pulse call for floor 3
    call_req = 3'b100; tick();
    chk("A_latch", 32'(pending), 32'h4);
    call_req = 3'b000; tick();
    chk("A_decide_busy", 32'(busy), 32'd1);
    chk("A_no_up_yet", 32'(up), 32'd0);
    tick();
    chk("A_up1", 32'(up), 32'd1);
    chk("A_floor1", 32'(fl), 32'd1);
    tick();
    chk("A_up1_single", 32'(up), 32'd0);
    chk("A_floor2", 32'(fl), 32'd2);
    tick();
    chk("A_gap", 32'(up), 32'd0);
    tick();
    chk("A_up2", 32'(up), 32'd1);
    tick();
    chk("A_floor3", 32'(fl), 32'd3);
    tick();
    chk("A_door", 32'(door_open), 32'd1);
    chk("A_pending_clr", 32'(pending), 32'd0);
    door_len("A_door_len", 0, 4);
    chk("A_idle", 32'(busy), 32'd0);

    // B: floor 2, dir up, calls for 1 and 3 together
    set_floor(2'd2);
    call_req = 3'b101; tick();
    chk("B_latch", 32'(pending), 32'h5);
    call_req = 3'b000; tick();
    tick();
    chk("B_up_first", 32'(up), 32'd1);
    chk("B_no_down", 32'(down), 32'd0);
    tick();
    chk("B_floor3", 32'(fl), 32'd3);
    tick();
    chk("B_door3", 32'(door_open), 32'd1);
    chk("B_pending_left", 32'(pending), 32'h1);
    door_len("B_door3_len", 0, 4);
    tick();
    chk("B_flip_no_pulse", 32'({up, down}), 32'd0);
    chk("B_flip_busy", 32'(busy), 32'd1);
    tick();
    chk("B_down1", 32'(down), 32'd1);
    tick();
    chk("B_floor2", 32'(fl), 32'd2);
    tick();
    tick();
    chk("B_down2", 32'(down), 32'd1);
    tick();
    chk("B_floor1", 32'(fl), 32'd1);
    tick();
    chk("B_door1", 32'(door_open), 32'd1);
    chk("B_pending_clr", 32'(pending), 32'd0);
    door_len("B_door1_len", 0, 4);

    // C: own-floor call, then repeat call extends the door
    set_floor(2'd2);
    call_req = 3'b010; tick();
    call_req = 3'b000; tick();
    chk("C_door", 32'(door_open), 32'd1);
    chk("C_no_move", 32'({up, down}), 32'd0);
    chk("C_pending_clr", 32'(pending), 32'd0);
    door_len("C_door_len", 0, 4);
    call_req = 3'b010; tick();
    call_req = 3'b000; tick();
    chk("C_door2", 32'(door_open), 32'd1);
    tick();
    call_req = 3'b010; tick();
    call_req = 3'b000;
    chk("C_absorb", 32'(pending), 32'd0);
    door_len("C_door_ext_len", 2, 6);

    // D: dir down at floor 2, calls both sides; set wins over a clear elsewhere
    call_req = 3'b101; tick();
    call_req = 3'b000; tick();
    tick();
    chk("D_continue_down", 32'({up, down}), 32'd1);
    tick();
    chk("D_floor1", 32'(fl), 32'd1);
    call_req = 3'b010; tick();
    call_req = 3'b000;
    chk("D_door1", 32'(door_open), 32'd1);
    chk("D_set_wins", 32'(pending), 32'h6);
    door_len("D_door_len", 0, 4);
    tick();
    tick();
    chk("D_flip_up", 32'({up, down}), 32'h2);
    drain("D_drain");
    chk("D_end_floor3", 32'(fl), 32'd3);

    // E: invalid floor blocks all action
    set_floor(2'd0);
    call_req = 3'b001; tick();
    call_req = 3'b000; tick();
    tick();
    chk("E_floor0_idle", 32'(busy), 32'd0);
    chk("E_floor0_pending", 32'(pending), 32'h1);
    chk("E_floor0_no_step", 32'({up, down}), 32'd0);
    set_floor(2'd1);
    tick();
    chk("E_door", 32'(door_open), 32'd1);
    chk("E_pending_clr", 32'(pending), 32'd0);
    drain("E_drain");

    // F: random calls against the floor model
    for (int i = 0; i < 400; i++) begin
      call_req = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      tick();
    end
    call_req = 3'b000;
    drain("F_drain");

    // G: reset mid-door drops outputs and loses calls
    set_floor(2'd1);
    call_req = 3'b101; tick();
    call_req = 3'b000; tick();
    chk("G_door", 32'(door_open), 32'd1);
    chk("G_pending", 32'(pending), 32'h4);
    #1 reset_n = 1'b0;
    #2;
    chk("G_rst_door", 32'(door_open), 32'd0);
    chk("G_rst_busy", 32'(busy), 32'd0);
    chk("G_rst_pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    tick();
    chk("G_calls_lost", 32'({pending, busy}), 32'd0);

`ifdef CALL_WATCHDOG_EN
    // W: floor frozen after an up pulse trips the watchdog
    set_floor(2'd1);
    freeze = 1'b1;
    call_req = 3'b100; tick();
    call_req = 3'b000; tick();
    tick();
    chk("W_up", 32'(up), 32'd1);
    repeat (7) tick();
    chk("W_not_yet", 32'(fault), 32'd0);
    tick();
    chk("W_fault", 32'(fault), 32'd1);
    chk("W_busy", 32'(busy), 32'd1);
    call_req = 3'b010; tick();
    call_req = 3'b000;
    chk("W_latch_in_fault", 32'(pending), 32'h6);
    chk("W_fault_held", 32'({fault, up, down, door_open}), 32'h8);
    reset_n = 1'b0;
    #2;
    chk("W_fault_rst", 32'(fault), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    freeze = 1'b0;
`else
    chk("fault_tied_low", 32'(fault), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
